// File: rtl/serial_addsub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives operands and start; slave returns status and results.
interface serial_addsub_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             s_bit;

   modport master (
      output start, sub, cin, a, b,
      input  busy, done, sum, cout, overflow, s_bit
   );

   modport slave (
      input  start, sub, cin, a, b,
      output busy, done, sum, cout, overflow, s_bit
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop process
// WIDTH operand bits LSB-first, then present sum, carry and signed overflow.
module serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input logic            clk,
   input logic            reset,
   serial_addsub_if.slave bus
);
   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic s;
   logic c_out;

   // Full-adder slice on the current LSBs and the running carry.
   always_comb begin
      s     = a_q[0] ^ b_q[0] ^ carry_q;
      c_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               // Subtract as a + ~b + ~cin so cout reads as not-borrow.
               a_d     = bus.a;
               b_d     = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? ~bus.cin : bus.cin;
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = c_out;
            res_d   = {s, res_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastBit) begin
               // carry_q is the carry into the MSB on this final bit.
               sum_d   = {s, res_q[WIDTH-1:1]};
               cout_d  = c_out;
               ovf_d   = carry_q ^ c_out;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Status and result outputs; s_bit is forced low outside RUN.
   always_comb begin
      bus.busy     = (state_q == StRun);
      bus.done     = (state_q == StDone);
      bus.sum      = sum_q;
      bus.cout     = cout_q;
      bus.overflow = ovf_q;
      bus.s_bit    = (state_q == StRun) & s;
   end
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8) against an arithmetic model.
module tb_serial_addsub;
   localparam int W = 8;

   logic clk;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   serial_addsub_if #(.WIDTH(W)) bus ();

   serial_addsub #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void ref_model(input logic sub_v, input logic cin_v,
                                     input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                                     output logic [W-1:0] s_o, output logic c_o,
                                     output logic o_o);
      longint ua, ub, sa, sb, r, sr, maxv, minv;
      ua   = longint'(a_v);
      ub   = longint'(b_v);
      sa   = longint'($signed(a_v));
      sb   = longint'($signed(b_v));
      maxv = (longint'(1) << (W - 1)) - 1;
      minv = -(longint'(1) << (W - 1));
      if (!sub_v) begin
         r   = ua + ub + longint'(cin_v);
         c_o = (r >= (longint'(1) << W));
         sr  = sa + sb + longint'(cin_v);
      end else begin
         r   = ua - ub - longint'(cin_v);
         c_o = (ua >= ub + longint'(cin_v));
         sr  = sa - sb - longint'(cin_v);
      end
      s_o = r[W-1:0];
      o_o = (sr > maxv) || (sr < minv);
   endfunction

   // Issue one operation and collect what the DUT shows up to its done pulse.
   task automatic run_op(input logic sub_v, input logic cin_v,
                         input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                         output logic [W-1:0] s_o, output logic c_o, output logic o_o,
                         output logic [W-1:0] sbits, output int lat, output logic busy_ok);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = sub_v;
      bus.cin   = cin_v;
      bus.a     = a_v;
      bus.b     = b_v;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.sub   = 1'($urandom);
      bus.cin   = 1'($urandom);
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      sbits     = '0;
      busy_ok   = 1'b1;
      lat       = 0;
      while (!bus.done && lat < 3 * W) begin
         if (lat < W) sbits[lat] = bus.s_bit;
         if (!bus.busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.busy) busy_ok = 1'b0;
      s_o = bus.sum;
      c_o = bus.cout;
      o_o = bus.overflow;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done);
      else pass_cnt++;
      total_cnt++;
      if (bus.sum !== '0) $display("FAIL reset_sum: got %h want 00", bus.sum);
      else pass_cnt++;
      total_cnt++;
      if ({bus.cout, bus.overflow, bus.s_bit} !== 3'b000)
         $display("FAIL reset_flags: got %b want 000", {bus.cout, bus.overflow, bus.s_bit});
      else pass_cnt++;
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta[4], tb[4], ts[4];
      logic         tsub[4], tc[4], to[4];
      logic [W-1:0] s, sb;
      logic         c, o, bok;
      int           lat;
      ta = '{8'h05, 8'h80, 8'h7F, 8'hFF};
      tb = '{8'h07, 8'h01, 8'h01, 8'h01};
      tsub = '{1'b1, 1'b1, 1'b0, 1'b0};
      ts = '{8'hFE, 8'h7F, 8'h80, 8'h00};
      tc = '{1'b0, 1'b1, 1'b0, 1'b1};
      to = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         run_op(tsub[i], 1'b0, ta[i], tb[i], s, c, o, sb, lat, bok);
         total_cnt++;
         if ({s, c, o} !== {ts[i], tc[i], to[i]})
            $display("FAIL directed_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     i, s, c, o, ts[i], tc[i], to[i]);
         else pass_cnt++;
         total_cnt++;
         if (lat !== W) $display("FAIL directed_latency_%0d: got %0d want %0d", i, lat, W);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a_v, b_v, s, sb, es;
      logic         sub_v, cin_v, c, o, bok, ec, eo;
      int           lat;
      for (int i = 0; i < 24; i++) begin
         a_v   = W'($urandom);
         b_v   = W'($urandom);
         sub_v = 1'($urandom);
         cin_v = 1'($urandom);
         ref_model(sub_v, cin_v, a_v, b_v, es, ec, eo);
         run_op(sub_v, cin_v, a_v, b_v, s, c, o, sb, lat, bok);
         total_cnt++;
         if ({s, c, o} !== {es, ec, eo})
            $display("FAIL random_result: op sub=%b cin=%b a=%h b=%h got %h/%b/%b want %h/%b/%b",
                     sub_v, cin_v, a_v, b_v, s, c, o, es, ec, eo);
         else pass_cnt++;
         total_cnt++;
         if (sb !== es) $display("FAIL random_s_bit: got %h want %h", sb, es);
         else pass_cnt++;
         total_cnt++;
         if (lat !== W) $display("FAIL random_latency: got %0d want %0d", lat, W);
         else pass_cnt++;
         total_cnt++;
         if (bok !== 1'b1) $display("FAIL random_busy: got %b want 1", bok);
         else pass_cnt++;
      end
   endtask

   task automatic test_hold();
      logic [W-1:0] s0;
      logic         c0, o0;
      s0 = bus.sum;
      c0 = bus.cout;
      o0 = bus.overflow;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.a     = W'($urandom);
         bus.b     = W'($urandom);
         @(posedge clk);
         #1;
         total_cnt++;
         if ({bus.sum, bus.cout, bus.overflow, bus.done} !== {s0, c0, o0, 1'b0})
            $display("FAIL hold: got %h/%b/%b done=%b want %h/%b/%b done=0",
                     bus.sum, bus.cout, bus.overflow, bus.done, s0, c0, o0);
         else pass_cnt++;
      end
   endtask

   task automatic test_start_ignored();
      logic [W-1:0] es;
      logic         ec, eo;
      int           lat;
      ref_model(1'b0, 1'b0, 8'h3C, 8'h5A, es, ec, eo);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b0;
      bus.a     = 8'h3C;
      bus.b     = 8'h5A;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b1;
      bus.a     = 8'hFF;
      bus.b     = 8'hFF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 4;
      while (!bus.done && lat < 3 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
      total_cnt++;
      if (lat !== W) $display("FAIL ignore_latency: got %0d want %0d", lat, W);
      else pass_cnt++;
      total_cnt++;
      if ({bus.sum, bus.cout, bus.overflow} !== {es, ec, eo})
         $display("FAIL ignore_result: got %h/%b/%b want %h/%b/%b",
                  bus.sum, bus.cout, bus.overflow, es, ec, eo);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if ({bus.done, bus.busy} !== 2'b00)
         $display("FAIL ignore_no_queue: got done/busy=%b%b want 00", bus.done, bus.busy);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] es1, es2;
      logic         ec1, eo1, ec2, eo2;
      int           lat, gap;
      ref_model(1'b0, 1'b1, 8'hA5, 8'h6E, es1, ec1, eo1);
      ref_model(1'b1, 1'b0, 8'h10, 8'h93, es2, ec2, eo2);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b1;
      bus.a     = 8'hA5;
      bus.b     = 8'h6E;
      @(posedge clk);
      #1;
      // start stays high: ignored in RUN, sampled again in DONE.
      bus.sub = 1'b1;
      bus.cin = 1'b0;
      bus.a   = 8'h10;
      bus.b   = 8'h93;
      lat = 0;
      while (!bus.done && lat < 3 * W) begin
         @(posedge clk);
         #1;
         lat++;
      end
      total_cnt++;
      if (lat !== W) $display("FAIL b2b_latency1: got %0d want %0d", lat, W);
      else pass_cnt++;
      total_cnt++;
      if ({bus.sum, bus.cout, bus.overflow} !== {es1, ec1, eo1})
         $display("FAIL b2b_result1: got %h/%b/%b want %h/%b/%b",
                  bus.sum, bus.cout, bus.overflow, es1, ec1, eo1);
      else pass_cnt++;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      total_cnt++;
      if ({bus.done, bus.busy} !== 2'b01)
         $display("FAIL b2b_restart: got done/busy=%b%b want 01", bus.done, bus.busy);
      else pass_cnt++;
      gap = 1;
      while (!bus.done && gap < 3 * W) begin
         @(posedge clk);
         #1;
         gap++;
      end
      // Cycles with done low between the two pulses.
      total_cnt++;
      if (gap - 1 !== W) $display("FAIL b2b_gap: got %0d want %0d", gap - 1, W);
      else pass_cnt++;
      total_cnt++;
      if ({bus.sum, bus.cout, bus.overflow} !== {es2, ec2, eo2})
         $display("FAIL b2b_result2: got %h/%b/%b want %h/%b/%b",
                  bus.sum, bus.cout, bus.overflow, es2, ec2, eo2);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] s, sb;
      logic         c, o, bok, saw_done;
      int           lat;
      run_op(1'b0, 1'b0, 8'h55, 8'h22, s, c, o, sb, lat, bok);
      @(negedge clk);
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.cin   = 1'b1;
      bus.a     = 8'hFF;
      bus.b     = 8'hFF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow, bus.s_bit} !== '0)
         $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b s_bit=%b want all 0",
                  bus.busy, bus.done, bus.sum, bus.cout, bus.overflow, bus.s_bit);
      else pass_cnt++;
      saw_done = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (bus.done) saw_done = 1'b1;
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (W + 2) begin
         @(posedge clk);
         #1;
         if (bus.done) saw_done = 1'b1;
      end
      total_cnt++;
      if (saw_done !== 1'b0) $display("FAIL midrun_no_done: got %b want 0", saw_done);
      else pass_cnt++;
      run_op(1'b0, 1'b0, 8'h12, 8'h34, s, c, o, sb, lat, bok);
      total_cnt++;
      if ({s, c} !== {8'h46, 1'b0})
         $display("FAIL after_reset_op: got %h/%b want 46/0", s, c);
      else pass_cnt++;
      total_cnt++;
      if (lat !== W) $display("FAIL after_reset_latency: got %0d want %0d", lat, W);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_hold();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no finish want finish before 1000000");
      $fatal(1);
   end
endmodule
